fp_add_sequencer: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder controller.
- Accepts one operand pair per transaction and selects the larger-magnitude operand (exponent first, then fraction when exponents are equal).
- Aligns the smaller mantissa one bit per cycle, then adds or subtracts, then normalises one bit per cycle.
- Sits between the operand-issue logic and the result writeback stage; replaces a fully combinational adder path where area matters more than latency.

---
 rtl/fp_add_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder controller.
// The smaller operand is aligned one bit per cycle. The sum is then
// normalised one bit per cycle. Rounding is truncation and denormals
// are flushed to zero.
module fp_add_sequencer #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        invalid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMPARE = 3'd1,
        S_ALIGN   = 3'd2,
        S_ADD     = 3'd3,
        S_NORM    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0]  LP_MAX_ALIGN = 8'(MAX_ALIGN);
    localparam logic [31:0] LP_QNAN      = 32'h7FC0_0000;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_a, w_a_nxt;
    logic [31:0] r_b, w_b_nxt;
    logic [23:0] r_big_mant, w_big_mant_nxt;
    logic [23:0] r_small_mant, w_small_mant_nxt;
    logic [24:0] r_sum, w_sum_nxt;
    logic [7:0]  r_shift_cnt, w_shift_cnt_nxt;
    logic [7:0]  r_exp, w_exp_nxt;
    logic        r_sign, w_sign_nxt;
    logic        r_eff_sub, w_eff_sub_nxt;
    logic [31:0] r_result, w_result_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        r_invalid, w_invalid_nxt;

    // Operand classification used in COMPARE. An exponent of 0 means a
    // zero or a denormal. Both are treated as zero, so the fraction and
    // the hidden bit are dropped.
    logic [7:0]  w_exp_a, w_exp_b;
    logic [22:0] w_frac_a, w_frac_b;
    logic [23:0] w_mant_a, w_mant_b;
    logic        w_frac_borrow;
    logic        w_a_big;
    logic [7:0]  w_exp_big, w_exp_small, w_exp_diff, w_shift_init;
    logic        w_special;
    logic [7:0]  w_exp_inc, w_exp_dec;
    logic [22:0] w_sum_shr_frac;

    assign w_exp_a  = r_a[30:23];
    assign w_exp_b  = r_b[30:23];
    assign w_frac_a = (w_exp_a == 8'd0) ? 23'd0 : r_a[22:0];
    assign w_frac_b = (w_exp_b == 8'd0) ? 23'd0 : r_b[22:0];
    assign w_mant_a = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_mant_b = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};

    // The borrow of fracA - fracB is set when B's fraction is larger.
    // When the magnitudes are equal there is no borrow, so A is selected.
    assign w_frac_borrow = 1'(({1'b0, w_frac_a} - {1'b0, w_frac_b}) >> 23);
    assign w_a_big       = (w_exp_a > w_exp_b) ||
                           ((w_exp_a == w_exp_b) && !w_frac_borrow);
    assign w_exp_big     = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small   = w_a_big ? w_exp_b : w_exp_a;
    assign w_exp_diff    = w_exp_big - w_exp_small;
    assign w_shift_init  = (w_exp_diff >= LP_MAX_ALIGN) ? LP_MAX_ALIGN : w_exp_diff;
    assign w_special     = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);

    assign w_exp_inc      = r_exp + 8'd1;
    assign w_exp_dec      = r_exp - 8'd1;
    assign w_sum_shr_frac = r_sum[23:1];

    // Next-state and datapath update. Every register holds its value by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_big_mant_nxt   = r_big_mant;
        w_small_mant_nxt = r_small_mant;
        w_sum_nxt        = r_sum;
        w_shift_cnt_nxt  = r_shift_cnt;
        w_exp_nxt        = r_exp;
        w_sign_nxt       = r_sign;
        w_eff_sub_nxt    = r_eff_sub;
        w_result_nxt     = r_result;
        w_ovf_nxt        = r_ovf;
        w_invalid_nxt    = r_invalid;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt       = a;
                    w_b_nxt       = b;
                    w_ovf_nxt     = 1'b0;
                    w_invalid_nxt = 1'b0;
                    w_state_nxt   = S_COMPARE;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end

            S_COMPARE: begin
                if (w_special) begin
                    w_result_nxt  = LP_QNAN;
                    w_invalid_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_big_mant_nxt   = w_a_big ? w_mant_a : w_mant_b;
                    w_small_mant_nxt = w_a_big ? w_mant_b : w_mant_a;
                    w_exp_nxt        = w_exp_big;
                    w_sign_nxt       = w_a_big ? r_a[31] : r_b[31];
                    w_eff_sub_nxt    = r_a[31] ^ r_b[31];
                    w_shift_cnt_nxt  = w_shift_init;
                    if (w_shift_init != 8'd0) begin
                        w_state_nxt = S_ALIGN;
                    end else begin
                        w_state_nxt = S_ADD;
                    end
                end
            end

            S_ALIGN: begin
                w_small_mant_nxt = r_small_mant >> 1;
                w_shift_cnt_nxt  = r_shift_cnt - 8'd1;
                if (r_shift_cnt == 8'd1) begin
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_ALIGN;
                end
            end

            S_ADD: begin
                // Because of how big and small were selected, the difference is never negative.
                if (r_eff_sub) begin
                    w_sum_nxt = {1'b0, r_big_mant} - {1'b0, r_small_mant};
                end else begin
                    w_sum_nxt = {1'b0, r_big_mant} + {1'b0, r_small_mant};
                end
                w_state_nxt = S_NORM;
            end

            S_NORM: begin
                if (r_sum[24]) begin
                    w_exp_nxt = w_exp_inc;
                    if (w_exp_inc == 8'hFF) begin
                        w_result_nxt = {r_sign, 8'hFF, 23'd0};
                        w_ovf_nxt    = 1'b1;
                    end else begin
                        w_result_nxt = {r_sign, w_exp_inc, w_sum_shr_frac};
                    end
                    w_state_nxt = S_DONE;
                end else if (r_sum == 25'd0) begin
                    w_result_nxt = 32'd0;
                    w_state_nxt  = S_DONE;
                end else if (r_sum[23]) begin
                    w_result_nxt = {r_sign, r_exp, r_sum[22:0]};
                    w_state_nxt  = S_DONE;
                end else begin
                    w_sum_nxt = {r_sum[23:0], 1'b0};
                    w_exp_nxt = w_exp_dec;
                    if (w_exp_dec == 8'd0) begin
                        w_result_nxt = {r_sign, 31'd0};
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt  = S_NORM;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_big_mant   <= 24'd0;
            r_small_mant <= 24'd0;
            r_sum        <= 25'd0;
            r_shift_cnt  <= 8'd0;
            r_exp        <= 8'd0;
            r_sign       <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_result     <= 32'd0;
            r_ovf        <= 1'b0;
            r_invalid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_big_mant   <= w_big_mant_nxt;
            r_small_mant <= w_small_mant_nxt;
            r_sum        <= w_sum_nxt;
            r_shift_cnt  <= w_shift_cnt_nxt;
            r_exp        <= w_exp_nxt;
            r_sign       <= w_sign_nxt;
            r_eff_sub    <= w_eff_sub_nxt;
            r_result     <= w_result_nxt;
            r_ovf        <= w_ovf_nxt;
            r_invalid    <= w_invalid_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign invalid   = r_invalid;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer. It uses directed vectors with
// hand-computed results and checks latency.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        invalid;

    fp_add_sequencer #(.MAX_ALIGN(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        logic [31:0] lat;
    } exp_t;

    exp_t  sb_q[$];
    string sb_name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, want);
        end
    endtask

    // Monitor. It records when each transaction is accepted and when it
    // first shows out_valid. It checks each completed result against the queue.
    int    acc_cyc   = 0;
    int    first_cyc = 0;
    bit    seen      = 1'b0;
    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got result=%h want no output", result);
                end else begin
                    mon_e  = sb_q.pop_front();
                    mon_nm = sb_name_q.pop_front();
                    check({mon_nm, "_result"}, result, mon_e.res);
                    check({mon_nm, "_ovf"}, {31'd0, ovf}, {31'd0, mon_e.ovf});
                    check({mon_nm, "_invalid"}, {31'd0, invalid}, {31'd0, mon_e.inv});
                    check({mon_nm, "_latency"}, 32'(first_cyc - acc_cyc + 1), mon_e.lat);
                end
                seen = 1'b0;
            end
        end
    end

    // Drives one operand pair. If push is set, the expected response is queued.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] er, input logic eo, input logic ei,
                         input int el, input string nm, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: got in_ready=0 want 1", nm);
        end
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        if (push) begin
            sb_q.push_back('{res: er, ovf: eo, inv: ei, lat: 32'(el)});
            sb_name_q.push_back(nm);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits, with a bound, until the monitor has consumed every queued expectation.
    task automatic drain(input string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got pending=%0d want 0", nm, sb_q.size());
            sb_q.delete();
            sb_name_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] er, input logic eo, input logic ei,
                       input int el, input string nm);
        issue(ta, tb_v, er, eo, ei, el, nm, 1'b1);
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_invalid",   {31'd0, invalid},   32'd0);

        run(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 4,  "one_plus_one");
        run(32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000, 1'b0, 1'b0, 5,  "one_plus_half");
        run(32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000, 1'b0, 1'b0, 5,  "half_plus_one");
        run(32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 1'b0, 1'b0, 5,  "sub_norm_left");
        run(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0, 4,  "cancel");
        run(32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000, 1'b0, 1'b0, 6,  "neg_big");
        run(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 4,  "overflow");
        run(32'h7F80_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b0, 1'b1, 2,  "inf_in");
        run(32'h3F80_0000, 32'hFFC0_0001, 32'h7FC0_0000, 1'b0, 1'b1, 2,  "nan_in_b");
        run(32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001, 1'b0, 1'b0, 27, "align_23");
        run(32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0, 1'b0, 29, "align_cap25");
        run(32'h0080_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 29, "align_cap_big");
        run(32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 4,  "denorm_flush");
        run(32'h80C0_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b0, 4,  "underflow_flush");

        // Back-pressure. The result must stay valid and stable, and new operands are ignored.
        out_ready = 1'b0;
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 4, "hold", 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
            check("hold_result",    result,             32'h4000_0000);
            a        = 32'h4040_0000;
            b        = 32'h4040_0000;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  {31'd0, in_ready},  32'd1);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        drain("hold");

        // Reset during ALIGN. The partial result must never be presented.
        issue(32'h3F80_0000, 32'h3380_0000, 32'd0, 1'b0, 1'b0, 0, "abort", 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result",    result,             32'd0);
        run(32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000, 1'b0, 1'b0, 5, "after_abort");
        run(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0, 28, "align_24");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
